// File: rtl/div_unit_controller.sv
// rtl/div_unit_controller.sv - iterative restoring divider with FREE/RESERVED/PROCESSING/FINISHED handshake
//
// Purpose:
//   Multi-cycle integer divider shared by the issue and execution stages.
//   The issue stage reserves it, the execution stage hands over operands,
//   one restoring step runs per cycle on operand magnitudes, and the result
//   (quotient or remainder, signed or unsigned) is held until released.
//
// Optional feature:
//   RSD_DIV_EARLY_OUT_EN - when defined, a zero divisor or a signed overflow
//   (most-negative / -1) skips the iteration and finishes one cycle after the
//   request is accepted. When undefined, every operation takes the full latency.
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset, overrides every other input
//   i_acquire     issue stage reserves the divider (FREE only)
//   i_flush       abort any operation, return to FREE
//   i_stall       execution-stage stall, blocks request acceptance
//   i_req         operands presented (RESERVED only)
//   i_data_in_a   dividend
//   i_data_in_b   divisor
//   i_div_code    0=DIV 1=DIVU 2=REM 3=REMU
//   i_release     consumer has taken the result (FINISHED only)
//   o_data_out    quotient or remainder, valid while o_finished
//   o_free        state FREE
//   o_reserved    state RESERVED
//   o_busy        state PROCESSING
//   o_finished    state FINISHED

module div_unit_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_acquire,
    input  logic                  i_flush,
    input  logic                  i_stall,
    input  logic                  i_req,
    input  logic [DATA_WIDTH-1:0] i_data_in_a,
    input  logic [DATA_WIDTH-1:0] i_data_in_b,
    input  logic [1:0]            i_div_code,
    input  logic                  i_release,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_free,
    output logic                  o_reserved,
    output logic                  o_busy,
    output logic                  o_finished
);

    localparam logic [1:0] S_FREE       = 2'd0;
    localparam logic [1:0] S_RESERVED   = 2'd1;
    localparam logic [1:0] S_PROCESSING = 2'd2;
    localparam logic [1:0] S_FINISHED   = 2'd3;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [1:0]            r_code;
    logic [DATA_WIDTH-1:0] r_dividend;   // raw dividend, needed for the special-case results
    logic [DATA_WIDTH-1:0] r_dvsr_mag;   // divisor magnitude
    logic [DATA_WIDTH-1:0] r_quo;        // dividend bits shift out the top, quotient bits in the bottom
    logic [DATA_WIDTH-1:0] r_rem;        // partial remainder, always below the divisor
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div_zero;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_data_out;

    // Operand conditioning at request time. Unsigned ops (odd codes) never negate.
    logic                  w_is_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_in_zero;
    logic                  w_in_ovf;
    logic                  w_accept;

    assign w_is_signed = ~i_div_code[0];
    assign w_a_neg     = w_is_signed & i_data_in_a[DATA_WIDTH-1];
    assign w_b_neg     = w_is_signed & i_data_in_b[DATA_WIDTH-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_a_mag     = w_a_neg ? (~i_data_in_a + 1'b1) : i_data_in_a;
    assign w_b_mag     = w_b_neg ? (~i_data_in_b + 1'b1) : i_data_in_b;
    assign w_in_zero   = (i_data_in_b == '0);
    assign w_in_ovf    = w_is_signed && (i_data_in_a == MOST_NEG) && (i_data_in_b == ALL_ONES);
    assign w_accept    = (r_state == S_RESERVED) && i_req && !i_stall;

    // One restoring step: shift the next dividend bit into the remainder and
    // keep the difference only when it did not borrow.
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_qbit;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_quo_next;
    logic                  w_last_step;

    assign w_shift     = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff      = w_shift - {1'b0, r_dvsr_mag};
    assign w_qbit      = ~w_diff[DATA_WIDTH];
    assign w_rem_next  = w_qbit ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_quo_next  = {r_quo[DATA_WIDTH-2:0], w_qbit};
    assign w_last_step = (r_cnt == LAST_STEP);

    // Final result is formed from the values of the last step so it can be
    // registered on the same edge that enters FINISHED.
    logic [DATA_WIDTH-1:0] w_quo_signed;
    logic [DATA_WIDTH-1:0] w_rem_signed;
    logic [DATA_WIDTH-1:0] w_final;

    assign w_quo_signed = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_signed = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    always_comb begin
        w_final = '0;
        if (r_div_zero) begin
            w_final = r_code[1] ? r_dividend : ALL_ONES;
        end else if (r_ovf) begin
            w_final = r_code[1] ? '0 : r_dividend;
        end else begin
            w_final = r_code[1] ? w_rem_signed : w_quo_signed;
        end
    end

`ifdef RSD_DIV_EARLY_OUT_EN
    // Special-case result straight from the request inputs.
    logic [DATA_WIDTH-1:0] w_early;

    always_comb begin
        w_early = '0;
        if (w_in_zero) begin
            w_early = i_div_code[1] ? i_data_in_a : ALL_ONES;
        end else begin
            w_early = i_div_code[1] ? '0 : i_data_in_a;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_FREE;
            r_cnt      <= '0;
            r_code     <= '0;
            r_dividend <= '0;
            r_dvsr_mag <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_data_out <= '0;
        end else if (i_flush) begin
            r_state <= S_FREE;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (i_acquire) begin
                        r_state <= S_RESERVED;
                    end
                end
                S_RESERVED: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_code     <= i_div_code;
                        r_dividend <= i_data_in_a;
                        r_dvsr_mag <= w_b_mag;
                        r_quo      <= w_a_mag;
                        r_rem      <= '0;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= w_in_zero;
                        r_ovf      <= w_in_ovf;
`ifdef RSD_DIV_EARLY_OUT_EN
                        if (w_in_zero || w_in_ovf) begin
                            r_state    <= S_FINISHED;
                            r_data_out <= w_early;
                        end else begin
                            r_state <= S_PROCESSING;
                        end
`else
                        r_state <= S_PROCESSING;
`endif
                    end
                end
                S_PROCESSING: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                    if (w_last_step) begin
                        r_state    <= S_FINISHED;
                        r_data_out <= w_final;
                    end
                end
                S_FINISHED: begin
                    if (i_release) begin
                        r_state <= S_FREE;
                    end
                end
                default: begin
                    r_state <= S_FREE;
                end
            endcase
        end
    end

    assign o_data_out = r_data_out;
    assign o_free     = (r_state == S_FREE);
    assign o_reserved = (r_state == S_RESERVED);
    assign o_busy     = (r_state == S_PROCESSING);
    assign o_finished = (r_state == S_FINISHED);

endmodule
